// File: rtl/goe_pkg.sv
// Shared constants and types for the GOE egress block.
// Header codes live in data-word bits [133:132]. PHV bit positions, FIFO
// depths, count widths and almost-full thresholds are defined here so the
// top level and the testbench-facing parameters stay consistent.
package goe_pkg;

  localparam int DATA_W = 134;
  localparam int PHV_W  = 1024;
  localparam int PORT_W = 8;

  // Word header field and its codes.
  localparam int         HDR_MSB  = 133;
  localparam logic [1:0] HDR_HEAD = 2'b01;
  localparam logic [1:0] HDR_BODY = 2'b11;
  localparam logic [1:0] HDR_TAIL = 2'b10;

  // PHV fields used by this block.
  localparam int PHV_DISCARD_BIT = 1023;
  localparam int PHV_PORT_LSB    = 1008;

  // FIFO geometry; count widths hold 0..DEPTH inclusive.
  localparam int DATA_DEPTH  = 256;
  localparam int VALID_DEPTH = 16;
  localparam int PHV_DEPTH   = 16;
  localparam int DATA_CNT_W  = $clog2(DATA_DEPTH) + 1;
  localparam int META_CNT_W  = $clog2(VALID_DEPTH) + 1;

  // Almost-full thresholds for the 16-deep metadata FIFOs.
  localparam logic [META_CNT_W-1:0] VALID_AF = 5'd12;
  localparam logic [META_CNT_W-1:0] PHV_AF   = 5'd12;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_DISCARD
  } goe_state_e;

  function automatic logic [1:0] word_hdr(input logic [DATA_W-1:0] word);
    return word[HDR_MSB -: 2];
  endfunction

endpackage

// File: rtl/goe_fifo.sv
// Synchronous show-ahead FIFO with a registered occupancy count.
// Ports:
//   clk, rst          clock, synchronous active-high reset (flushes pointers/count)
//   wr_en, wr_data    push; ignored while full
//   rd_en, rd_data    pop; rd_data always shows the oldest entry
//   count             registered occupancy 0..DEPTH
//   empty, full       decoded from count
//   ovf               single-cycle pulse when a push hits a full FIFO
module goe_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full,
  output logic             ovf
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_wr_ok;
  logic             w_rd_ok;

  assign empty   = (r_count == '0);
  assign full    = (r_count == CNT_W'(DEPTH));
  assign w_wr_ok = wr_en && !full;
  assign w_rd_ok = rd_en && !empty;
  assign ovf     = wr_en && full;
  assign count   = r_count;
  assign rd_data = r_mem[r_rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd_ok) r_rd_ptr <= r_rd_ptr + AW'(1);
      unique case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the flushed pointers and count
  // make stale contents unreachable, and an unreset array maps onto RAM.
  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[r_wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/goe.sv
// GOE: store-and-forward packet egress. Packet words, keep flags and PHVs
// are buffered in three FIFOs; once a packet's keep flag and PHV are both
// present it is either forwarded (head word tagged with the PHV port) or
// dropped silently.
// Ports:
//   clk, rst                                  clock, synchronous active-high reset
//   in_goe_data/_wr, in_goe_valid/_wr         packet words and keep flag from pgm
//   in_goe_phv/_wr                            one PHV per packet
//   out_goe_alf, out_goe_phv_alf              registered almost-full to pgm
//   out_goe_data/_wr, out_goe_valid/_wr       packet egress (registered)
//   out_goe_port                              egress port, valid with head word
//   in_goe_alf                                egress backpressure
//   cin_/cout_goe_data/_wr, *_ready           config pass-through
//   goe_pkt_in_cnt/out_cnt/drop_cnt           statistics (wrap at 2^32)
//   goe_ovf_err                               sticky FIFO overflow
module goe
  import goe_pkg::*;
#(
  parameter                        PLATFORM = "Xilinx",
  parameter logic [7:0]            LMID     = 8'd7,
  parameter logic [DATA_CNT_W-1:0] AF_DATA  = 9'd224
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_goe_data,
  input  logic              in_goe_data_wr,
  input  logic              in_goe_valid,
  input  logic              in_goe_valid_wr,
  output logic              out_goe_alf,
  input  logic [PHV_W-1:0]  in_goe_phv,
  input  logic              in_goe_phv_wr,
  output logic              out_goe_phv_alf,
  output logic [DATA_W-1:0] out_goe_data,
  output logic              out_goe_data_wr,
  output logic              out_goe_valid,
  output logic              out_goe_valid_wr,
  input  logic              in_goe_alf,
  output logic [PORT_W-1:0] out_goe_port,
  input  logic [DATA_W-1:0] cin_goe_data,
  input  logic              cin_goe_data_wr,
  output logic              cout_goe_ready,
  output logic [DATA_W-1:0] cout_goe_data,
  output logic              cout_goe_data_wr,
  input  logic              cin_goe_ready,
  output logic [31:0]       goe_pkt_in_cnt,
  output logic [31:0]       goe_pkt_out_cnt,
  output logic [31:0]       goe_drop_cnt,
  output logic              goe_ovf_err
);

  goe_state_e r_state, w_state_nxt;

  logic [DATA_W-1:0]     w_data_rd;
  logic [DATA_CNT_W-1:0] w_data_count;
  logic                  w_data_empty, w_data_full, w_data_ovf;
  logic                  w_valid_rd;
  logic [META_CNT_W-1:0] w_valid_count;
  logic                  w_valid_empty, w_valid_full, w_valid_ovf;
  logic [PHV_W-1:0]      w_phv_rd;
  logic [META_CNT_W-1:0] w_phv_count;
  logic                  w_phv_empty, w_phv_full, w_phv_ovf;

  logic                  w_pop_meta, w_pop_data, w_emit;
  logic                  w_drop_pkt, w_is_head, w_is_tail;

  logic [DATA_W-1:0]     r_out_data;
  logic                  r_out_data_wr, r_out_valid_wr;
  logic [PORT_W-1:0]     r_out_port, r_port;
  logic                  r_alf, r_phv_alf, r_ovf;
  logic [DATA_W-1:0]     r_cout_data;
  logic                  r_cout_data_wr;
  logic [31:0]           r_pkt_in_cnt, r_pkt_out_cnt, r_drop_cnt;

  goe_fifo #(.WIDTH(DATA_W), .DEPTH(DATA_DEPTH)) u_data_fifo (
    .clk(clk), .rst(rst), .wr_en(in_goe_data_wr), .wr_data(in_goe_data),
    .rd_en(w_pop_data), .rd_data(w_data_rd), .count(w_data_count),
    .empty(w_data_empty), .full(w_data_full), .ovf(w_data_ovf)
  );

  goe_fifo #(.WIDTH(1), .DEPTH(VALID_DEPTH)) u_valid_fifo (
    .clk(clk), .rst(rst), .wr_en(in_goe_valid_wr), .wr_data(in_goe_valid),
    .rd_en(w_pop_meta), .rd_data(w_valid_rd), .count(w_valid_count),
    .empty(w_valid_empty), .full(w_valid_full), .ovf(w_valid_ovf)
  );

  goe_fifo #(.WIDTH(PHV_W), .DEPTH(PHV_DEPTH)) u_phv_fifo (
    .clk(clk), .rst(rst), .wr_en(in_goe_phv_wr), .wr_data(in_goe_phv),
    .rd_en(w_pop_meta), .rd_data(w_phv_rd), .count(w_phv_count),
    .empty(w_phv_empty), .full(w_phv_full), .ovf(w_phv_ovf)
  );

  assign w_drop_pkt = !w_valid_rd || w_phv_rd[PHV_DISCARD_BIT];
  assign w_is_head  = (word_hdr(w_data_rd) == HDR_HEAD);
  assign w_is_tail  = (word_hdr(w_data_rd) == HDR_TAIL);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: every always_comb output gets a default before the case so no
  // path leaves a signal unassigned, which would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_pop_meta  = 1'b0;
    w_pop_data  = 1'b0;
    w_emit      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        // Keep flag arrives after the tail, so both metadata FIFOs being
        // non-empty means the whole packet is already in the data FIFO.
        if (!w_valid_empty && !w_phv_empty) begin
          w_pop_meta  = 1'b1;
          w_state_nxt = w_drop_pkt ? ST_DISCARD : ST_SEND;
        end
      end
      ST_SEND: begin
        if (!in_goe_alf && !w_data_empty) begin
          w_pop_data = 1'b1;
          w_emit     = 1'b1;
          if (w_is_tail) w_state_nxt = ST_IDLE;
        end
      end
      ST_DISCARD: begin
        if (!w_data_empty) begin
          w_pop_data = 1'b1;
          if (w_is_tail) w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data     <= '0;
      r_out_data_wr  <= 1'b0;
      r_out_valid_wr <= 1'b0;
      r_out_port     <= '0;
      r_port         <= '0;
      r_alf          <= 1'b0;
      r_phv_alf      <= 1'b0;
      r_ovf          <= 1'b0;
      r_cout_data    <= '0;
      r_cout_data_wr <= 1'b0;
      r_pkt_in_cnt   <= '0;
      r_pkt_out_cnt  <= '0;
      r_drop_cnt     <= '0;
    end else begin
      // Egress outputs return to zero on any cycle without a word.
      r_out_data     <= w_emit ? w_data_rd : '0;
      r_out_data_wr  <= w_emit;
      r_out_valid_wr <= w_emit && w_is_tail;
      r_out_port     <= (w_emit && w_is_head) ? r_port : '0;
      if (w_pop_meta) r_port <= w_phv_rd[PHV_PORT_LSB +: PORT_W];

      r_alf     <= (w_data_count >= AF_DATA) || (w_valid_count >= VALID_AF);
      r_phv_alf <= (w_phv_count >= PHV_AF);
      r_ovf     <= r_ovf || w_data_ovf || w_valid_ovf || w_phv_ovf;

      r_cout_data    <= cin_goe_data_wr ? cin_goe_data : '0;
      r_cout_data_wr <= cin_goe_data_wr;

      if (in_goe_valid_wr)          r_pkt_in_cnt  <= r_pkt_in_cnt + 32'd1;
      if (w_emit && w_is_tail)      r_pkt_out_cnt <= r_pkt_out_cnt + 32'd1;
      if (w_pop_meta && w_drop_pkt) r_drop_cnt    <= r_drop_cnt + 32'd1;
    end
  end

  assign out_goe_data     = r_out_data;
  assign out_goe_data_wr  = r_out_data_wr;
  assign out_goe_valid_wr = r_out_valid_wr;
  assign out_goe_valid    = r_out_valid_wr;
  assign out_goe_port     = r_out_port;
  assign out_goe_alf      = r_alf;
  assign out_goe_phv_alf  = r_phv_alf;
  assign goe_ovf_err      = r_ovf;
  assign cout_goe_data    = r_cout_data;
  assign cout_goe_data_wr = r_cout_data_wr;
  assign cout_goe_ready   = cin_goe_ready;
  assign goe_pkt_in_cnt   = r_pkt_in_cnt;
  assign goe_pkt_out_cnt  = r_pkt_out_cnt;
  assign goe_drop_cnt     = r_drop_cnt;

  // Identity parameters and PHV fields owned by downstream blocks are not
  // consumed here; folding them makes that explicit.
  logic w_unused;
  assign w_unused = ^{LMID, PLATFORM, w_data_full, w_valid_full, w_phv_full,
                      w_phv_rd[PHV_DISCARD_BIT-1:PHV_PORT_LSB+PORT_W],
                      w_phv_rd[PHV_PORT_LSB-1:0]};

endmodule

// File: tb/tb_goe.sv
// Self-checking bench for goe: directed packets, scoreboard queue filled at
// stimulus time and drained by an independent egress monitor.
module tb_goe;

  logic          clk = 1'b0;
  logic          rst;
  logic [133:0]  in_goe_data;
  logic          in_goe_data_wr, in_goe_valid, in_goe_valid_wr;
  logic          out_goe_alf;
  logic [1023:0] in_goe_phv;
  logic          in_goe_phv_wr, out_goe_phv_alf;
  logic [133:0]  out_goe_data;
  logic          out_goe_data_wr, out_goe_valid, out_goe_valid_wr;
  logic          in_goe_alf;
  logic [7:0]    out_goe_port;
  logic [133:0]  cin_goe_data, cout_goe_data;
  logic          cin_goe_data_wr, cout_goe_ready, cout_goe_data_wr, cin_goe_ready;
  logic [31:0]   goe_pkt_in_cnt, goe_pkt_out_cnt, goe_drop_cnt;
  logic          goe_ovf_err;

  always #5 clk = ~clk;

  goe dut (
    .clk(clk), .rst(rst),
    .in_goe_data(in_goe_data), .in_goe_data_wr(in_goe_data_wr),
    .in_goe_valid(in_goe_valid), .in_goe_valid_wr(in_goe_valid_wr),
    .out_goe_alf(out_goe_alf),
    .in_goe_phv(in_goe_phv), .in_goe_phv_wr(in_goe_phv_wr),
    .out_goe_phv_alf(out_goe_phv_alf),
    .out_goe_data(out_goe_data), .out_goe_data_wr(out_goe_data_wr),
    .out_goe_valid(out_goe_valid), .out_goe_valid_wr(out_goe_valid_wr),
    .in_goe_alf(in_goe_alf), .out_goe_port(out_goe_port),
    .cin_goe_data(cin_goe_data), .cin_goe_data_wr(cin_goe_data_wr),
    .cout_goe_ready(cout_goe_ready), .cout_goe_data(cout_goe_data),
    .cout_goe_data_wr(cout_goe_data_wr), .cin_goe_ready(cin_goe_ready),
    .goe_pkt_in_cnt(goe_pkt_in_cnt), .goe_pkt_out_cnt(goe_pkt_out_cnt),
    .goe_drop_cnt(goe_drop_cnt), .goe_ovf_err(goe_ovf_err)
  );

  typedef struct {
    logic [133:0] data;
    logic [7:0]   port;
    logic         tail;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic alf_q = 1'b0;

  task automatic check(input string name, input logic [287:0] act, input logic [287:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1023:0] mk_phv(input logic discard, input logic [7:0] port);
    logic [1023:0] p;
    p = {32{32'hA5C3_1E0F}};  // filler that must not leak into port/discard
    p[1023] = discard;
    p[1015:1008] = port;
    return p;
  endfunction

  function automatic logic [133:0] mk_word(input int i, input int n, input logic [127:0] base);
    logic [1:0] hdr;
    logic [3:0] ibc;
    hdr = (i == 0) ? 2'b01 : (i == n - 1) ? 2'b10 : 2'b11;
    ibc = (i == n - 1) ? 4'h3 : 4'h0;
    return {hdr, ibc, base + 128'(i)};
  endfunction

  task automatic send_pkt(input int n, input logic keep, input logic [1023:0] phv,
                          input logic [127:0] base);
    logic expect_out;
    exp_t e;
    expect_out = keep && !phv[1023];
    in_goe_phv = phv; in_goe_phv_wr = 1'b1;
    tick();
    in_goe_phv_wr = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_goe_data = mk_word(i, n, base); in_goe_data_wr = 1'b1;
      if (expect_out) begin
        e.data = in_goe_data;
        e.port = (i == 0) ? phv[1015:1008] : 8'h00;
        e.tail = (i == n - 1);
        sb_q.push_back(e);
      end
      tick();
    end
    in_goe_data_wr = 1'b0; in_goe_data = '0;
    in_goe_valid = keep; in_goe_valid_wr = 1'b1;
    tick();
    in_goe_valid_wr = 1'b0; in_goe_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int c;
    c = 0;
    while (sb_q.size() != 0 && c < 300) begin tick(); c++; end
    repeat (3) tick();
    check({name, "_drained"}, 288'(sb_q.size()), 288'd0);
  endtask

  task automatic do_reset();
    in_goe_data_wr = 1'b0; in_goe_valid_wr = 1'b0; in_goe_phv_wr = 1'b0;
    in_goe_alf = 1'b0; cin_goe_data_wr = 1'b0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    sb_q.delete();
  endtask

  // Egress monitor: every word must match the queue head; otherwise idle zeros.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      alf_q = in_goe_alf;
      @(negedge clk);
      if (out_goe_data_wr === 1'b1) begin
        check("egress_while_alf", 288'(alf_q), 288'd0);
        check("egress_expected", 288'(sb_q.size() != 0), 288'd1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("egress_data", 288'(out_goe_data), 288'(e.data));
          check("egress_port", 288'(out_goe_port), 288'(e.port));
          check("egress_tail", 288'({out_goe_valid_wr, out_goe_valid}), 288'({e.tail, e.tail}));
        end
      end else begin
        check("egress_idle_zero",
              288'({out_goe_data, out_goe_port, out_goe_valid_wr, out_goe_valid}), 288'd0);
      end
    end
  end

  initial begin
    in_goe_data = '0; in_goe_data_wr = 1'b0; in_goe_valid = 1'b0; in_goe_valid_wr = 1'b0;
    in_goe_phv = '0; in_goe_phv_wr = 1'b0; in_goe_alf = 1'b0;
    cin_goe_data = '0; cin_goe_data_wr = 1'b0; cin_goe_ready = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    check("reset_outputs",
          {out_goe_data, out_goe_data_wr, out_goe_valid, out_goe_valid_wr, out_goe_port,
           out_goe_alf, out_goe_phv_alf, cout_goe_data, cout_goe_data_wr, cout_goe_ready,
           goe_ovf_err}, 288'd0);
    check("reset_counters", 288'({goe_pkt_in_cnt, goe_pkt_out_cnt, goe_drop_cnt}), 288'd0);
    rst = 1'b0;
    tick();

    // Config pass-through: one registered cycle; ready is combinational.
    cin_goe_data = {2'b01, 4'h0, 128'hC0FF_EE00_1234}; cin_goe_data_wr = 1'b1; cin_goe_ready = 1'b1;
    tick();
    cin_goe_data_wr = 1'b0;
    check("cfg_forward", 288'({cout_goe_data, cout_goe_data_wr, cout_goe_ready}),
          288'({2'b01, 4'h0, 128'hC0FF_EE00_1234, 1'b1, 1'b1}));
    cin_goe_ready = 1'b0;
    tick();
    check("cfg_idle", 288'({cout_goe_data, cout_goe_data_wr, cout_goe_ready}), 288'd0);

    // Basic 3-word kept packet to port 3.
    send_pkt(3, 1'b1, mk_phv(1'b0, 8'h03), 128'h1000);
    drain("basic");
    check("cnt_basic", 288'({goe_pkt_in_cnt, goe_pkt_out_cnt, goe_drop_cnt}),
          288'({32'd1, 32'd1, 32'd0}));

    // keep=0 packet is discarded.
    send_pkt(4, 1'b0, mk_phv(1'b0, 8'h05), 128'h2000);
    repeat (20) tick();
    check("cnt_keep0", 288'({goe_pkt_in_cnt, goe_pkt_out_cnt, goe_drop_cnt}),
          288'({32'd2, 32'd1, 32'd1}));

    // PHV discard bit overrides keep=1.
    do_reset();
    send_pkt(2, 1'b1, mk_phv(1'b1, 8'h07), 128'h2500);
    repeat (20) tick();
    check("cnt_phv_discard", 288'({goe_pkt_in_cnt, goe_pkt_out_cnt, goe_drop_cnt}),
          288'({32'd1, 32'd0, 32'd1}));

    // 10-word packet with four cycles of egress backpressure after word 2.
    begin : t_alf
      int seen, first_c, tail_c, stall;
      bit stalled;
      seen = 0; first_c = -1; tail_c = -1; stall = 0; stalled = 1'b0;
      send_pkt(10, 1'b1, mk_phv(1'b0, 8'h0A), 128'h3000);
      for (int c = 0; c < 200 && tail_c < 0; c++) begin
        @(negedge clk);
        if (stall > 0) begin
          stall--;
          if (stall == 0) in_goe_alf = 1'b0;
        end
        if (out_goe_data_wr === 1'b1) begin
          seen++;
          if (first_c < 0) first_c = c;
          if (out_goe_valid_wr === 1'b1) tail_c = c;
          if (seen == 2 && !stalled) begin
            in_goe_alf = 1'b1; stall = 4; stalled = 1'b1;
          end
        end
      end
      in_goe_alf = 1'b0;
      check("alf_word_count", 288'(seen), 288'd10);
      check("alf_span_cycles", 288'(tail_c - first_c), 288'd13);
      drain("alf");
    end

    // Reset after the second egress word of a 5-word packet.
    begin : t_rst
      int seen;
      do_reset();
      seen = 0;
      send_pkt(5, 1'b1, mk_phv(1'b0, 8'h05), 128'h4000);
      for (int c = 0; c < 200 && seen < 2; c++) begin
        @(negedge clk);
        if (out_goe_data_wr === 1'b1) seen++;
      end
      check("rst_mid_word2_seen", 288'(seen), 288'd2);
      rst = 1'b1;
      tick();
      sb_q.delete();
      rst = 1'b0;
      @(negedge clk);
      check("rst_mid_outputs",
            288'({out_goe_data, out_goe_data_wr, out_goe_valid, out_goe_valid_wr,
                  out_goe_port, goe_pkt_in_cnt, goe_pkt_out_cnt, goe_drop_cnt}), 288'd0);
      repeat (10) tick();
      send_pkt(3, 1'b1, mk_phv(1'b0, 8'h06), 128'h5000);
      drain("post_rst");
      check("cnt_post_rst", 288'({goe_pkt_in_cnt, goe_pkt_out_cnt, goe_drop_cnt}),
            288'({32'd1, 32'd1, 32'd0}));
    end

    // Fill data FIFO with no egress: alf threshold, then overflow.
    do_reset();
    for (int i = 1; i <= 257; i++) begin
      in_goe_data = {2'b11, 4'h0, 128'(i)}; in_goe_data_wr = 1'b1;
      tick();
      if (i == 224) check("alf_at_224", 288'(out_goe_alf), 288'd0);
      if (i == 225) check("alf_after_224", 288'(out_goe_alf), 288'd1);
      if (i == 256) check("ovf_at_256", 288'(goe_ovf_err), 288'd0);
      if (i == 257) check("ovf_at_257", 288'(goe_ovf_err), 288'd1);
    end
    in_goe_data_wr = 1'b0;
    tick();
    check("ovf_sticky", 288'(goe_ovf_err), 288'd1);

    // PHV almost-full at 12 entries, one cycle late.
    for (int j = 0; j < 12; j++) begin
      in_goe_phv = mk_phv(1'b0, 8'(j)); in_goe_phv_wr = 1'b1;
      tick();
    end
    in_goe_phv_wr = 1'b0;
    check("phv_alf_at_12", 288'(out_goe_phv_alf), 288'd0);
    tick();
    check("phv_alf_after_12", 288'(out_goe_phv_alf), 288'd1);

    do_reset();
    check("final_reset", 288'({goe_ovf_err, out_goe_alf, out_goe_phv_alf}), 288'd0);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
